// File: rtl/dac_tx_sequencer.sv
// DAC transmit sequencer: IDLE -> SYNC -> ALIGN -> STREAM with underrun recovery.
// Define DAC_UNDERRUN_CNT_EN to add the saturating o_underrun_cnt output.
module dac_tx_sequencer #(
  parameter int unsigned SYNC_CYCLES  = 16,
  parameter int unsigned FRAME_PERIOD = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  input  logic [63:0] i_s_data,
  output logic        o_sync,
  output logic        o_frame,
  output logic        o_samples_vld,
  output logic [15:0] o_chan_a_sample_0,
  output logic [15:0] o_chan_a_sample_1,
  output logic [15:0] o_chan_b_sample_0,
  output logic [15:0] o_chan_b_sample_1,
  output logic [2:0]  o_state,
  output logic        o_underrun,
  input  logic        i_clear_underrun
`ifdef DAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0] o_underrun_cnt
`endif
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SYNC     = 3'd1;
  localparam logic [2:0] ST_ALIGN    = 3'd2;
  localparam logic [2:0] ST_STREAM   = 3'd3;
  localparam logic [2:0] ST_UNDERRUN = 3'd4;

  localparam logic [15:0] SYNC_LAST  = 16'(SYNC_CYCLES - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_PERIOD - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] sync_cnt_q, sync_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        sync_q, sync_d;
  logic        frame_q, frame_d;
  logic        vld_q, vld_d;
  logic        underrun_q, underrun_d;
  logic [63:0] smp_q, smp_d;

  logic beat_acc;
  logic underrun_evt;
  logic frame_wrap;

  assign o_s_ready    = (state_q == ST_STREAM) && i_enable;
  assign beat_acc     = o_s_ready && i_s_valid;
  assign underrun_evt = o_s_ready && !i_s_valid;
  assign frame_wrap   = beat_acc && (frame_cnt_q == FRAME_LAST);

  // Next-state logic; a low enable overrides every other transition.
  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (!i_enable) begin
      state_d     = ST_IDLE;
      sync_cnt_d  = 16'd0;
      frame_cnt_d = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SYNC;
          sync_cnt_d = 16'd0;
        end
        ST_SYNC: begin
          if (sync_cnt_q == SYNC_LAST) begin
            state_d    = ST_ALIGN;
            sync_cnt_d = 16'd0;
          end else begin
            sync_cnt_d = sync_cnt_q + 16'd1;
          end
        end
        ST_ALIGN: begin
          // The ALIGN cycle itself carries frame position 0.
          state_d     = ST_STREAM;
          frame_cnt_d = 16'd1;
        end
        ST_STREAM: begin
          if (i_s_valid) begin
            frame_cnt_d = frame_wrap ? 16'd0 : frame_cnt_q + 16'd1;
          end else begin
            state_d     = ST_UNDERRUN;
            frame_cnt_d = 16'd0;
          end
        end
        ST_UNDERRUN: begin
          if (i_s_valid) state_d = ST_ALIGN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output registers follow the next state so pulses line up with o_state.
  always_comb begin
    sync_d  = (state_d == ST_SYNC);
    frame_d = (state_d == ST_ALIGN) || frame_wrap;
    vld_d   = beat_acc;
    smp_d   = beat_acc ? i_s_data : 64'd0;
    if (underrun_evt)          underrun_d = 1'b1;
    else if (i_clear_underrun) underrun_d = 1'b0;
    else                       underrun_d = underrun_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      sync_cnt_q  <= 16'd0;
      frame_cnt_q <= 16'd0;
      sync_q      <= 1'b0;
      frame_q     <= 1'b0;
      vld_q       <= 1'b0;
      underrun_q  <= 1'b0;
      smp_q       <= 64'd0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      sync_q      <= sync_d;
      frame_q     <= frame_d;
      vld_q       <= vld_d;
      underrun_q  <= underrun_d;
      smp_q       <= smp_d;
    end
  end

`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // A clear coinciding with a new underrun restarts the count at one.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_evt) begin
      if (i_clear_underrun)       ucnt_d = 16'd1;
      else if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end else if (i_clear_underrun) begin
      ucnt_d = 16'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ucnt_q <= 16'd0;
    else          ucnt_q <= ucnt_d;
  end

  assign o_underrun_cnt = ucnt_q;
`endif

  assign o_state           = state_q;
  assign o_sync            = sync_q;
  assign o_frame           = frame_q;
  assign o_samples_vld     = vld_q;
  assign o_underrun        = underrun_q;
  assign o_chan_a_sample_0 = smp_q[15:0];
  assign o_chan_a_sample_1 = smp_q[31:16];
  assign o_chan_b_sample_0 = smp_q[47:32];
  assign o_chan_b_sample_1 = smp_q[63:48];

endmodule

// File: tb/tb_dac_tx_sequencer.sv
// Directed table-driven bench for dac_tx_sequencer (SYNC_CYCLES=4, FRAME_PERIOD=8).
`timescale 1ns/1ps
module tb_dac_tx_sequencer;

  typedef struct {
    logic        en;
    logic        vld;
    logic        clr;
    logic [63:0] data;
    logic        exp_rdy;
    logic [2:0]  exp_st;
    logic        exp_sync;
    logic        exp_frame;
    logic        exp_svld;
    logic [63:0] exp_smp;
    logic        exp_und;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        sync_o;
  logic        frame_o;
  logic        svld_o;
  logic [15:0] a0, a1, b0, b1;
  logic [2:0]  state_o;
  logic        und_o;
  logic        clr;
`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0] ucnt_o;
`endif

  int checks = 0;
  int errs   = 0;
  vec_t tbl[$];

  dac_tx_sequencer #(.SYNC_CYCLES(4), .FRAME_PERIOD(8)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_enable          (en),
    .i_s_valid         (s_valid),
    .o_s_ready         (s_ready),
    .i_s_data          (s_data),
    .o_sync            (sync_o),
    .o_frame           (frame_o),
    .o_samples_vld     (svld_o),
    .o_chan_a_sample_0 (a0),
    .o_chan_a_sample_1 (a1),
    .o_chan_b_sample_0 (b0),
    .o_chan_b_sample_1 (b1),
    .o_state           (state_o),
    .o_underrun        (und_o),
    .i_clear_underrun  (clr)
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt    (ucnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  function automatic logic [63:0] beat(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {16'h3000 + kk, 16'h2000 + kk, 16'h1000 + kk, kk};
  endfunction

  function automatic vec_t mk(input logic e, input logic v, input logic c, input logic [63:0] d,
                              input logic rdy, input logic [2:0] st, input logic sy,
                              input logic fr, input logic sv, input logic [63:0] smp,
                              input logic un);
    vec_t r;
    r.en = e; r.vld = v; r.clr = c; r.data = d;
    r.exp_rdy = rdy; r.exp_st = st; r.exp_sync = sy; r.exp_frame = fr;
    r.exp_svld = sv; r.exp_smp = smp; r.exp_und = un;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk($sformatf("%s.ready", tag), 64'(s_ready), 64'(v.exp_rdy));
    chk($sformatf("%s.state", tag), 64'(state_o), 64'(v.exp_st));
    chk($sformatf("%s.sync", tag), 64'(sync_o), 64'(v.exp_sync));
    chk($sformatf("%s.frame", tag), 64'(frame_o), 64'(v.exp_frame));
    chk($sformatf("%s.svld", tag), 64'(svld_o), 64'(v.exp_svld));
    chk($sformatf("%s.samples", tag), {b1, b0, a1, a0}, v.exp_smp);
    chk($sformatf("%s.underrun", tag), 64'(und_o), 64'(v.exp_und));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    en = v.en; s_valid = v.vld; clr = v.clr; s_data = v.data;
    #1;
    chk_outs(tag, v);
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("%s[%0d]", tag, i), tbl[i]);
    tbl.delete();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; clr = 1'b0; s_data = 64'd0;
    #1;
    chk_outs("reset", mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 64'd0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Start-up, 32 streamed beats, a 3-cycle underrun, clear, then disable.
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 64'd0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 64'd0, 0));
    tbl.push_back(mk(1, 1, 0, beat(1), 0, 3'd2, 0, 1, 0, 64'd0, 0));
    for (int k = 1; k <= 32; k++)
      tbl.push_back(mk(1, 1, 0, beat(k), 1, 3'd3, 0, (k % 8) == 0, k > 1,
                       (k > 1) ? beat(k - 1) : 64'd0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 3'd3, 0, 0, 1, beat(32), 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd4, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd4, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(1, 1, 0, beat(41), 0, 3'd4, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(1, 1, 0, beat(41), 0, 3'd2, 0, 1, 0, 64'd0, 1));
    tbl.push_back(mk(1, 1, 0, beat(41), 1, 3'd3, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(1, 1, 1, beat(42), 1, 3'd3, 0, 0, 1, beat(41), 1));
    tbl.push_back(mk(0, 1, 0, beat(43), 0, 3'd3, 0, 0, 1, beat(42), 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 64'd0, 0));
    run_tbl("main");

    // Clear and a new underrun in the same cycle: set must win.
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 64'd0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 64'd0, 0));
    tbl.push_back(mk(1, 1, 0, beat(100), 0, 3'd2, 0, 1, 0, 64'd0, 0));
    tbl.push_back(mk(1, 1, 0, beat(100), 1, 3'd3, 0, 0, 0, 64'd0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 3'd3, 0, 0, 1, beat(100), 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd4, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd4, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 64'd0, 1));
    run_tbl("setwins");
`ifdef DAC_UNDERRUN_CNT_EN
    chk("underrun_cnt", 64'(ucnt_o), 64'd1);
`endif

    // Asynchronous reset in the middle of SYNC, then a full restart.
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 64'd0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 64'd0, 1));
    run_tbl("prerst");
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("rst_async", mk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 64'd0, 0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_outs("rst_release", mk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 64'd0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 64'd0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd2, 0, 1, 0, 64'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1'b0, 3'd3, 0, 0, 0, 64'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 64'd0, 0));
    run_tbl("restart");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dac_tx_sequencer.md
DAC_TX_SEQUENCER -- requirements
Module: dac_tx_sequencer

Interface
REQ-001 SHALL have parameter SYNC_CYCLES, default 16: number of cycles o_sync is held high during start-up (range 1..65535).
REQ-002 SHALL have parameter FRAME_PERIOD, default 1024: number of cycles between o_frame pulses while streaming (range 2..65536).
REQ-003 SHALL use one clock and an asynchronous active-low reset; all logic SHALL sit in the DAC SCLK domain.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- i_clk  in  1  DAC SCLK-domain clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  level: 1 = run sequence, 0 = return to IDLE.
- i_s_valid  in  1  upstream sample beat valid.
- o_s_ready  out  1  beat accepted when i_s_valid && o_s_ready.
- i_s_data  in  64  {chan_b_s1, chan_b_s0, chan_a_s1, chan_a_s0}, 16 bits each.
- o_sync  out  1  DAC sync level.
- o_frame  out  1  DAC frame pulse.
- o_samples_vld  out  1  output samples valid.
- o_chan_a_sample_0, o_chan_a_sample_1, o_chan_b_sample_0, o_chan_b_sample_1  out  16 each  registered samples.
- o_state  out  3  current FSM state encoding.
- o_underrun  out  1  sticky underrun flag.
- i_clear_underrun  in  1  one-cycle pulse that clears o_underrun.

Function
REQ-005 FSM states and encodings SHALL be IDLE=0, SYNC=1, ALIGN=2, STREAM=3, UNDERRUN=4.
REQ-006 In IDLE, all outputs except o_state/o_underrun SHALL be 0; i_enable=1 -> SYNC on the next cycle.
REQ-007 In SYNC, o_sync SHALL be 1 for exactly SYNC_CYCLES cycles, then -> ALIGN.
REQ-008 In ALIGN (one cycle): o_frame=1, o_sync=0, no beat accepted, frame counter loaded to 1; -> STREAM.
REQ-009 o_s_ready SHALL be combinational: 1 only when state==STREAM && i_enable.
REQ-010 In STREAM, an accepted beat SHALL appear on the sample outputs with o_samples_vld=1 exactly 1 cycle later (latency 1).
REQ-011 In STREAM, the frame counter SHALL increment modulo FRAME_PERIOD; o_frame SHALL be 1 for one cycle when the counter wraps to 0, aligned with the sample registered in that cycle.
REQ-012 In STREAM, with i_s_valid=0: the next cycle SHALL have o_samples_vld=0, all sample outputs 0, and o_underrun set to 1; FSM -> UNDERRUN.
REQ-013 In UNDERRUN: o_s_ready=0 and sample outputs 0; when i_s_valid=1 -> ALIGN (frame re-issued before data resumes).
REQ-014 i_enable=0 in any state SHALL force IDLE on the next cycle, override every other transition, zero o_sync/o_frame/o_samples_vld/samples, and accept no beat that cycle.
REQ-015 If i_clear_underrun and a new underrun occur in the same cycle, set SHALL win.
REQ-016 Whenever o_samples_vld=0, sample outputs SHALL be 0.

Reset
REQ-017 When i_rst_n=0: state=IDLE, counters=0, and all outputs 0 (including o_underrun), asynchronously.
REQ-018 Reset deassertion mid-sequence SHALL restart from IDLE; no partial SYNC/frame pulse SHALL be emitted.

Configuration
REQ-019 Macro DAC_UNDERRUN_CNT_EN: when defined, add output o_underrun_cnt (16 bits). It SHALL increment on each STREAM->UNDERRUN transition, saturate at 16'hFFFF, and clear on i_clear_underrun or reset.
REQ-020 Without DAC_UNDERRUN_CNT_EN, the port and counter SHALL be absent and all other behaviour identical.

Verification (SYNC_CYCLES=4, FRAME_PERIOD=8)
REQ-021 Reset, then i_enable=1 -> o_sync high for exactly 4 cycles, one-cycle o_frame, then o_s_ready=1; o_state sequence 0,1,1,1,1,2,3.
REQ-022 Continuous valid beats 0x0001..0x0020 -> each appears 1 cycle after acceptance with o_samples_vld=1; o_frame every 8 cycles after ALIGN.
REQ-023 Drop i_s_valid for 3 cycles mid-stream -> o_underrun=1, outputs 0, state 4; on valid return: state 2 with frame pulse, then data resumes at latency 1.
REQ-024 i_enable=0 concurrent with i_s_valid=1 in STREAM -> o_s_ready=0, no beat accepted, state 0 next cycle.
REQ-025 Assert i_rst_n=0 during SYNC -> outputs 0 immediately; after release with i_enable=1, full 4-cycle sync is repeated.
REQ-026 With DAC_UNDERRUN_CNT_EN: 3 underruns -> o_underrun_cnt=3; simultaneous clear and underrun -> o_underrun=1.
